pipeline_hazard_ctrl: RTL and testbench

//  Central pipeline controller for the 4-stage core (IF, ID, EX, WB).
//  - Register scoreboard: holds an instruction in ID while a source register still has a write in flight.
//  - Taken branches: flushes IF/ID and injects a bubble into ID/EX.
//  - Debug: halt, single-step and resume, using a drain FSM.
//  - Perf: saturating count of hazard-stall cycles.

---
 rtl/pipeline_hazard_if.sv | 37 +++
 rtl/pipeline_hazard_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_if.sv
// Pipeline-side control bundle between the datapath and pipeline_hazard_ctrl.
// master: datapath (drives ID/EX/WB status, receives freeze/flush/bubble controls)
// slave : hazard controller
//   id_valid, id_rs1, id_rs2, id_use1, id_use2, id_rd, id_wr : ID-stage instruction info
//   ex_br_taken                                            : EX branch resolved taken
//   wb_we, wb_rd                                           : WB register-file write
//   stall_if, bubble_ex, flush_ifid, issue                 : pipeline controls
interface pipeline_hazard_if #(
  parameter int unsigned RW = 3
) ();
  logic          id_valid;
  logic [RW-1:0] id_rs1;
  logic [RW-1:0] id_rs2;
  logic          id_use1;
  logic          id_use2;
  logic [RW-1:0] id_rd;
  logic          id_wr;
  logic          ex_br_taken;
  logic          wb_we;
  logic [RW-1:0] wb_rd;
  logic          stall_if;
  logic          bubble_ex;
  logic          flush_ifid;
  logic          issue;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use1, id_use2, id_rd, id_wr,
    output ex_br_taken, wb_we, wb_rd,
    input  stall_if, bubble_ex, flush_ifid, issue
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use1, id_use2, id_rd, id_wr,
    input  ex_br_taken, wb_we, wb_rd,
    output stall_if, bubble_ex, flush_ifid, issue
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard/flush/debug controller for the 4-stage IF/ID/EX/WB core.
// Keeps a per-register pending-write scoreboard, stalls ID on RAW (and on
// pending-counter overflow), flushes on taken branches, implements debug
// halt / single-step / resume via a drain FSM, and counts hazard stalls.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   bus (slave)           : ID/EX/WB status in, stall/bubble/flush/issue out
//   halt_req              : level-sampled halt request
//   step_req, resume_req  : honoured only while halted
//   scnt_clr              : synchronous clear of stall_cnt
//   halted                : core drained and stopped (registered)
//   sb_err                : sticky scoreboard underflow/overflow flag
//   stall_cnt             : saturating hazard-stall cycle count
module pipeline_hazard_ctrl #(
  parameter int unsigned NREG   = 8,
  parameter int unsigned RW     = $clog2(NREG),
  parameter int unsigned PEND_W = 2,
  parameter int unsigned SCNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  pipeline_hazard_if.slave  bus,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic              resume_req,
  input  logic              scnt_clr,
  output logic              halted,
  output logic              sb_err,
  output logic [SCNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {StRun, StDrain, StHalted, StStep} state_e;

  localparam logic [PEND_W-1:0] PendMax = '1;
  localparam logic [SCNT_W-1:0] ScntMax = '1;

  state_e            state_q, state_d;
  logic              stepped_q, stepped_d;
  logic              halted_q, halted_d;
  logic              sb_err_q, sb_err_d;
  logic [SCNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PEND_W-1:0] pend_q [NREG];
  logic [PEND_W-1:0] pend_d [NREG];

  logic haz;
  logic go;
  logic any_pend;
  logic issue_int;

  // No bypass from WB: hazard looks only at registered pending counts.
  always_comb begin
    haz = bus.id_valid &
          ((bus.id_use1 & (pend_q[bus.id_rs1] != '0)) |
           (bus.id_use2 & (pend_q[bus.id_rs2] != '0)) |
           (bus.id_wr   & (pend_q[bus.id_rd] == PendMax)));
  end

  always_comb begin
    any_pend = 1'b0;
    for (int unsigned r = 0; r < NREG; r++) begin
      any_pend = any_pend | (pend_q[r] != '0);
    end
  end

  // Halt request blocks issue in the same cycle it is seen in RUN.
  assign go = ((state_q == StRun) & ~halt_req) | ((state_q == StStep) & ~stepped_q);

  // Pipeline controls, branch flush has top priority in every state.
  always_comb begin
    bus.stall_if   = 1'b1;
    bus.bubble_ex  = 1'b1;
    bus.flush_ifid = 1'b0;
    issue_int      = 1'b0;
    if (!reset) begin
      // held at reset values
    end else if (bus.ex_br_taken) begin
      bus.flush_ifid = 1'b1;
      bus.stall_if   = 1'b0;
    end else if (go && !haz) begin
      issue_int     = bus.id_valid;
      bus.stall_if  = 1'b0;
      bus.bubble_ex = ~bus.id_valid;
    end
  end

  assign bus.issue = issue_int;

  // Scoreboard: +1 on issued write, -1 on WB write, both cancel.
  always_comb begin
    logic inc;
    logic dec;
    sb_err_d = sb_err_q;
    for (int unsigned r = 0; r < NREG; r++) begin
      pend_d[r] = pend_q[r];
      inc = issue_int & bus.id_wr & (bus.id_rd == RW'(r));
      dec = bus.wb_we & (bus.wb_rd == RW'(r));
      if (inc && !dec) begin
        if (pend_q[r] == PendMax) sb_err_d = 1'b1;
        else                      pend_d[r] = pend_q[r] + PEND_W'(1);
      end else if (dec && !inc) begin
        if (pend_q[r] == '0) sb_err_d = 1'b1;
        else                 pend_d[r] = pend_q[r] - PEND_W'(1);
      end
    end
  end

  // Debug FSM
  always_comb begin
    state_d   = state_q;
    stepped_d = stepped_q;
    case (state_q)
      StRun: begin
        if (halt_req) state_d = StDrain;
      end
      StDrain: begin
        if (!any_pend && !bus.ex_br_taken) state_d = StHalted;
      end
      StHalted: begin
        if (resume_req) begin
          state_d = StRun;
        end else if (step_req) begin
          state_d   = StStep;
          stepped_d = 1'b0;
        end
      end
      StStep: begin
        if (issue_int) begin
          stepped_d = 1'b1;
          state_d   = StDrain;
        end
      end
      default: state_d = StRun;
    endcase
    halted_d = (state_d == StHalted);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (scnt_clr) begin
      stall_cnt_d = '0;
    end else if ((state_q == StRun) && haz && !bus.ex_br_taken && (stall_cnt_q != ScntMax)) begin
      stall_cnt_d = stall_cnt_q + SCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StRun;
      stepped_q   <= 1'b0;
      halted_q    <= 1'b0;
      sb_err_q    <= 1'b0;
      stall_cnt_q <= '0;
      for (int unsigned r = 0; r < NREG; r++) begin
        pend_q[r] <= '0;
      end
    end else begin
      state_q     <= state_d;
      stepped_q   <= stepped_d;
      halted_q    <= halted_d;
      sb_err_q    <= sb_err_d;
      stall_cnt_q <= stall_cnt_d;
      for (int unsigned r = 0; r < NREG; r++) begin
        pend_q[r] <= pend_d[r];
      end
    end
  end

  assign halted    = halted_q;
  assign sb_err    = sb_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: the driver pushes hand-computed
// expected outputs per cycle; a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic        halt_req, step_req, resume_req, scnt_clr;
  logic        halted, sb_err;
  logic [15:0] stall_cnt;

  pipeline_hazard_if #(.RW(3)) bus ();

  pipeline_hazard_ctrl #(
    .NREG(8), .RW(3), .PEND_W(2), .SCNT_W(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .halt_req   (halt_req),
    .step_req   (step_req),
    .resume_req (resume_req),
    .scnt_clr   (scnt_clr),
    .halted     (halted),
    .sb_err     (sb_err),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int          id;
    logic        stall;
    logic        bubble;
    logic        flush;
    logic        issue;
    logic        hlt;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  task automatic cmp(input string name, input int id, input logic [15:0] act,
                     input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, id, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp("stall_if",   e.id, 16'(bus.stall_if),   16'(e.stall));
      cmp("bubble_ex",  e.id, 16'(bus.bubble_ex),  16'(e.bubble));
      cmp("flush_ifid", e.id, 16'(bus.flush_ifid), 16'(e.flush));
      cmp("issue",      e.id, 16'(bus.issue),      16'(e.issue));
      cmp("halted",     e.id, 16'(halted),         16'(e.hlt));
      cmp("sb_err",     e.id, 16'(sb_err),         16'(e.err));
      cmp("stall_cnt",  e.id, stall_cnt,           e.cnt);
    end
  end

  // Push expectation for the current cycle's inputs, then advance one cycle.
  task automatic expect_c(input logic s, input logic b, input logic f, input logic i,
                          input logic h, input logic e, input logic [15:0] c);
    exp_t x;
    x.id = vec_id; x.stall = s; x.bubble = b; x.flush = f; x.issue = i;
    x.hlt = h; x.err = e; x.cnt = c;
    exp_q.push_back(x);
    vec_id++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_valid = 1'b0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use1 = 1'b0;
    bus.id_use2 = 1'b0; bus.id_rd = '0; bus.id_wr = 1'b0; bus.ex_br_taken = 1'b0;
    bus.wb_we = 1'b0; bus.wb_rd = '0;
    halt_req = 1'b0; step_req = 1'b0; resume_req = 1'b0; scnt_clr = 1'b0;
  endtask

  task automatic wr_only(input logic [2:0] rd);
    bus.id_valid = 1'b1; bus.id_wr = 1'b1; bus.id_rd = rd;
  endtask

  task automatic rd1(input logic [2:0] r);
    bus.id_valid = 1'b1; bus.id_use1 = 1'b1; bus.id_rs1 = r;
  endtask

  task automatic rd2(input logic [2:0] r);
    bus.id_valid = 1'b1; bus.id_use2 = 1'b1; bus.id_rs2 = r;
  endtask

  task automatic wb(input logic [2:0] r);
    bus.wb_we = 1'b1; bus.wb_rd = r;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    @(posedge clk);
    #1;
    // Reset values with a valid instruction present
    idle(); bus.id_valid = 1'b1; expect_c(1, 1, 0, 0, 0, 0, 0);
    reset = 1'b1;

    // RAW on r3 released the cycle after WB
    idle(); wr_only(3);         expect_c(0, 0, 0, 1, 0, 0, 0);
    idle(); rd1(3);             expect_c(1, 1, 0, 0, 0, 0, 0);
    idle(); rd1(3); wb(3);      expect_c(1, 1, 0, 0, 0, 0, 1);
    idle(); rd1(3);             expect_c(0, 0, 0, 1, 0, 0, 2);
    idle();                     expect_c(0, 1, 0, 0, 0, 0, 2);

    // Two writes in flight to r2
    idle(); wr_only(2);         expect_c(0, 0, 0, 1, 0, 0, 2);
    idle(); wr_only(2);         expect_c(0, 0, 0, 1, 0, 0, 2);
    idle(); rd2(2); wb(2);      expect_c(1, 1, 0, 0, 0, 0, 2);
    idle(); rd2(2);             expect_c(1, 1, 0, 0, 0, 0, 3);
    idle(); rd2(2); wb(2);      expect_c(1, 1, 0, 0, 0, 0, 4);
    idle(); rd2(2);             expect_c(0, 0, 0, 1, 0, 0, 5);

    // Taken branch while hazard-stalled
    idle(); wr_only(5);         expect_c(0, 0, 0, 1, 0, 0, 5);
    idle(); rd1(5);             expect_c(1, 1, 0, 0, 0, 0, 5);
    idle(); rd1(5); bus.ex_br_taken = 1'b1; expect_c(0, 1, 1, 0, 0, 0, 6);
    idle();                     expect_c(0, 1, 0, 0, 0, 0, 6);
    idle(); rd1(5); wb(5);      expect_c(1, 1, 0, 0, 0, 0, 6);
    idle();                     expect_c(0, 1, 0, 0, 0, 0, 7);
    // Flushed write must not mark r4 pending
    idle(); wr_only(4); bus.ex_br_taken = 1'b1; expect_c(0, 1, 1, 0, 0, 0, 7);
    idle(); rd1(4);             expect_c(0, 0, 0, 1, 0, 0, 7);

    // Halt with r1 pending, single step, resume
    idle(); wr_only(1);         expect_c(0, 0, 0, 1, 0, 0, 7);
    idle(); bus.id_valid = 1'b1; halt_req = 1'b1;          expect_c(1, 1, 0, 0, 0, 0, 7);
    idle(); bus.id_valid = 1'b1; halt_req = 1'b1; wb(1);   expect_c(1, 1, 0, 0, 0, 0, 7);
    idle(); bus.id_valid = 1'b1;                           expect_c(1, 1, 0, 0, 0, 0, 7);
    idle(); bus.id_valid = 1'b1; step_req = 1'b1;          expect_c(1, 1, 0, 0, 1, 0, 7);
    idle();                                                expect_c(0, 1, 0, 0, 0, 0, 7);
    idle(); bus.id_valid = 1'b1;                           expect_c(0, 0, 0, 1, 0, 0, 7);
    idle(); bus.id_valid = 1'b1;                           expect_c(1, 1, 0, 0, 0, 0, 7);
    idle(); bus.id_valid = 1'b1; step_req = 1'b1; resume_req = 1'b1;
    expect_c(1, 1, 0, 0, 1, 0, 7);
    idle(); bus.id_valid = 1'b1;                           expect_c(0, 0, 0, 1, 0, 0, 7);

    // WB to idle register sets sticky error
    idle(); wb(7);              expect_c(0, 1, 0, 0, 0, 0, 7);
    idle();                     expect_c(0, 1, 0, 0, 0, 1, 7);
    idle();                     expect_c(0, 1, 0, 0, 0, 1, 7);

    // Clear, then saturate the stall counter
    idle(); wr_only(0);         expect_c(0, 0, 0, 1, 0, 1, 7);
    idle(); rd1(0); scnt_clr = 1'b1; expect_c(1, 1, 0, 0, 0, 1, 7);
    idle(); rd1(0);             expect_c(1, 1, 0, 0, 0, 1, 0);
    for (int k = 0; k < 65540; k++) begin
      @(posedge clk);
      #1;
    end
    idle(); rd1(0);             expect_c(1, 1, 0, 0, 0, 1, 16'hFFFF);
    idle(); rd1(0);             expect_c(1, 1, 0, 0, 0, 1, 16'hFFFF);
    idle(); rd1(0); scnt_clr = 1'b1; expect_c(1, 1, 0, 0, 0, 1, 16'hFFFF);
    idle(); rd1(0);             expect_c(1, 1, 0, 0, 0, 1, 0);

    // Asynchronous reset mid-stall
    reset = 1'b0;
    idle(); rd1(0);             expect_c(1, 1, 0, 0, 0, 0, 0);
    idle(); rd1(0);             expect_c(1, 1, 0, 0, 0, 0, 0);
    reset = 1'b1;
    idle(); rd1(0);             expect_c(0, 0, 0, 1, 0, 0, 0);
    idle();                     expect_c(0, 1, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    cmp("queue_drained", -1, 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
